// File: rtl/jtcop_dispbus_arb.sv
// jtcop_dispbus_arb
// Shares the single display-RAM port (BAC06 tile/scroll RAM) between the 68000
// and the video tilemap fetcher. Video owns the port during active display.
// A CPU access is held off (cpu_busy) until a blank starts. It is then served
// in a fixed WAIT_CYC-cycle window. cpu_busy feeds the bus_busy term of the
// main CPU DTACK generator.
//
// Handshakes:
//   CPU side: cpu_cs is a level request held for the whole bus cycle.
//     cpu_busy is its not-ready term. The transfer is complete in the first
//     cycle with cpu_cs=1 and cpu_busy=0, and cpu_din is valid in that cycle.
//   Video side: vid_req is a one-cycle valid with no ready. It is always
//     accepted, and answered by exactly one vid_ack pulse with vid_data valid
//     in the same cycle.
//
// Ports:
//   clk, rstn             clock, synchronous active-low reset
//   LVBL, LHBL            vertical / horizontal blank, active low
//   cpu_cs, cpu_we        CPU select (level) and write flag
//   cpu_dsn               {UDSn,LDSn}, active-low byte enables
//   cpu_addr, cpu_dout    CPU word address and write data
//   cpu_din               CPU read data
//   cpu_busy              stall request to the DTACK logic
//   vid_req, vid_addr     video fetch request (one cycle per word) and address
//   vid_ack, vid_data     video read data strobe and data
//   ram_addr, ram_we      RAM address and active-high byte write enables
//   ram_din, ram_dout     RAM write data and 1-cycle synchronous read data
//   state_dbg             arbiter state: 0 IDLE, 1 WAIT_BLANK, 2 ACCESS, 3 DONE
//
// DW is expected to be 16: the two byte lanes map onto ram_we[1:0].
module jtcop_dispbus_arb #(
   parameter int AW       = 13,
   parameter int DW       = 16,
   parameter int WAIT_CYC = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          LVBL,
   input  logic          LHBL,
   input  logic          cpu_cs,
   input  logic          cpu_we,
   input  logic [1:0]    cpu_dsn,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_dout,
   output logic [DW-1:0] cpu_din,
   output logic          cpu_busy,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [DW-1:0] vid_data,
   output logic [AW-1:0] ram_addr,
   output logic [1:0]    ram_we,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic [1:0]    state_dbg
);

   localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_BLANK = 2'd1,
      ACCESS     = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          cs_l;

   // CPU request captured on the cs rising edge and held until IDLE
   logic          req_we;
   logic [1:0]    req_dsn;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_dout;

   // one stored video request, raised while the CPU owns the port
   logic          pend;
   logic [AW-1:0] pend_addr;

   logic [DW-1:0] vid_data_q;

   logic          blank;
   logic          cs_rise;
   logic          in_access;
   logic          vid_go;
   logic [AW-1:0] vid_go_addr;
   logic          acc_first;
   logic          acc_last;

   assign blank       = ~LVBL | ~LHBL;
   assign cs_rise     = cpu_cs & ~cs_l;
   assign in_access   = (state == ACCESS);
   // video gets the port in every cycle the CPU is not in its access window;
   // a stored request is older than a new one, so it goes first
   assign vid_go      = ~in_access & (vid_req | pend);
   assign vid_go_addr = pend ? pend_addr : vid_addr;
   assign acc_first   = in_access & (cnt == CW'(WAIT_CYC - 1));
   assign acc_last    = in_access & (cnt == '0);

   // next state
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (cs_rise) state_nx = WAIT_BLANK;
         end
         WAIT_BLANK: begin
            if (!cpu_cs) begin
               state_nx = IDLE;
            end else if (blank && !vid_go) begin
               // video wins a tie: the CPU grant slips by a cycle
               state_nx = ACCESS;
               cnt_nx   = CW'(WAIT_CYC - 1);
            end
         end
         ACCESS: begin
            // committed: neither blank ending nor cs dropping aborts it
            if (acc_last) state_nx = cpu_cs ? DONE : IDLE;
            else          cnt_nx   = cnt - CW'(1);
         end
         DONE: begin
            if (!cpu_cs) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // port outputs
   always_comb begin
      cpu_busy  = cpu_cs & (state != DONE);
      ram_addr  = in_access ? req_addr : vid_go_addr;
      // gated by rstn so that no write reaches the RAM in a reset cycle
      ram_we    = (acc_first && rstn) ? (~req_dsn & {2{req_we}}) : 2'b00;
      ram_din   = req_dout;
      // the synchronous RAM answers in the ack cycle; hold the word afterwards
      vid_data  = vid_ack ? ram_dout : vid_data_q;
      state_dbg = state;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         cnt        <= '0;
         cs_l       <= 1'b0;
         req_we     <= 1'b0;
         req_dsn    <= 2'b11;
         req_addr   <= '0;
         req_dout   <= '0;
         pend       <= 1'b0;
         pend_addr  <= '0;
         cpu_din    <= '0;
         vid_ack    <= 1'b0;
         vid_data_q <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         cs_l  <= cpu_cs;

         if (state == IDLE && cs_rise) begin
            req_we   <= cpu_we;
            req_dsn  <= cpu_dsn;
            req_addr <= cpu_addr;
            req_dout <= cpu_dout;
         end

         // the address went out on the first access cycle, so by the last
         // cycle ram_dout holds the addressed word
         if (acc_last && !req_we) cpu_din <= ram_dout;

         vid_ack <= vid_go;
         if (vid_ack) vid_data_q <= ram_dout;

         if (in_access) begin
            if (vid_req && !pend) begin
               pend      <= 1'b1;
               pend_addr <= vid_addr;
            end
         end else begin
            // the stored request is served now; a new one arriving in the
            // same cycle takes its place
            pend <= pend & vid_req;
            if (pend && vid_req) pend_addr <= vid_addr;
         end
      end
   end

endmodule

// File: tb/tb_jtcop_dispbus_arb.sv
// Testbench for jtcop_dispbus_arb: a synchronous RAM model, randomized CPU and
// video traffic, and a shadow memory plus timing rules as the reference.
module tb_jtcop_dispbus_arb;

   localparam int AW       = 13;
   localparam int DW       = 16;
   localparam int WAIT_CYC = 2;
   localparam int DEPTH    = 1 << AW;

   logic          clk;
   logic          rstn;
   logic          LVBL, LHBL;
   logic          cpu_cs, cpu_we;
   logic [1:0]    cpu_dsn;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_dout;
   logic [DW-1:0] cpu_din;
   logic          cpu_busy;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_ack;
   logic [DW-1:0] vid_data;
   logic [AW-1:0] ram_addr;
   logic [1:0]    ram_we;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic [1:0]    state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // RAM model
   logic [DW-1:0] mem    [DEPTH];
   logic [DW-1:0] shadow [DEPTH];
   logic          preload;
   logic [15:0]   ram_seed;

   // scoreboard: expected video words and the cycle of their ack
   logic [DW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   logic [DW-1:0] obs_q[$];
   int            obs_cyc_q[$];

   int            we_total = 0;
   logic [1:0]    last_we  = 2'b00;
   logic [DW-1:0] exp_din;

   jtcop_dispbus_arb #(.AW(AW), .DW(DW), .WAIT_CYC(WAIT_CYC)) dut (
      .clk(clk), .rstn(rstn), .LVBL(LVBL), .LHBL(LHBL),
      .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_dsn(cpu_dsn),
      .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
      .cpu_busy(cpu_busy), .vid_req(vid_req), .vid_addr(vid_addr),
      .vid_ack(vid_ack), .vid_data(vid_data), .ram_addr(ram_addr),
      .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ram_init(input int i);
      return 16'(i * 40503) ^ ram_seed;
   endfunction

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= ram_init(i);
      end else begin
         if (ram_we[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
         if (ram_we[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      end
      ram_dout <= mem[ram_addr];
   end

   // monitor: log video acks and write-enable cycles
   always @(negedge clk) begin
      if (vid_ack) begin
         obs_q.push_back(vid_data);
         obs_cyc_q.push_back(cyc);
      end
      if (ram_we != 2'b00) begin
         we_total <= we_total + 1;
         last_we  <= ram_we;
      end
   end

   // ---------------- reference timing ----------------
   // Cycle 0 is the cycle cs rises. The rise is seen at the end of that cycle,
   // so the earliest grant is cycle 1, or the first blank cycle after that.
   // A video request in the grant cycle wins and pushes the grant one cycle on.
   function automatic int model_grant(input int blank_dly, input int vid_cyc);
      int g;
      g = (blank_dly < 1) ? 1 : blank_dly;
      if (vid_cyc == g) g = g + 1;
      return g;
   endfunction

   // Relative cycle of vid_ack. A request made during the CPU window is served
   // in the first cycle after it and acked one cycle later.
   function automatic int model_ack(input int blank_dly, input int vid_cyc);
      int g;
      g = model_grant(blank_dly, vid_cyc);
      if (vid_cyc > g && vid_cyc <= g + WAIT_CYC) return g + WAIT_CYC + 2;
      return vid_cyc + 1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cpu_txn(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [1:0] dsn,
                          input int blank_dly, input int vid_cyc,
                          input logic [AW-1:0] vaddr,
                          output int busy_cnt, output logic [DW-1:0] rdata,
                          output int we_seen, output logic [1:0] we_pat);
      int c;
      int start;
      int we0;
      we0      = we_total;
      busy_cnt = 0;
      c        = 0;
      @(posedge clk); #1;
      start    = cyc;
      cpu_cs   = 1'b1;
      cpu_we   = we;
      cpu_addr = addr;
      cpu_dout = data;
      cpu_dsn  = dsn;
      forever begin
         if (c >= blank_dly) LHBL = 1'b0;
         if (c == vid_cyc) begin
            vid_req  = 1'b1;
            vid_addr = vaddr;
            exp_q.push_back(shadow[vaddr]);
            exp_cyc_q.push_back(start + model_ack(blank_dly, vid_cyc));
         end else begin
            vid_req = 1'b0;
         end
         @(negedge clk);
         if (!cpu_busy) break;
         busy_cnt++;
         if (c > 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL cpu_txn_timeout: busy still high after %0d cycles, required release", c);
            break;
         end
         @(posedge clk); #1;
         c++;
      end
      rdata = cpu_din;
      @(posedge clk); #1;
      cpu_cs  = 1'b0;
      vid_req = 1'b0;
      LHBL    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      we_seen = we_total - we0;
      we_pat  = last_we;
      if (we) begin
         if (!dsn[0]) shadow[addr][7:0]  = data[7:0];
         if (!dsn[1]) shadow[addr][15:8] = data[15:8];
      end
   endtask

   task automatic check_video(input string tag);
      logic [DW-1:0] d, e;
      int            oc, ec;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         d  = obs_q.pop_front();
         oc = obs_cyc_q.pop_front();
         e  = exp_q.pop_front();
         ec = exp_cyc_q.pop_front();
         n_checks++;
         if (d !== e || oc !== ec) begin
            n_fail++;
            $display("FAIL %s vid_ack: data %h at cycle %0d, required %h at cycle %0d",
                     tag, d, oc, e, ec);
         end
      end
      n_checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s vid_count: %0d acks unmatched, %0d expected acks missing",
                  tag, obs_q.size(), exp_q.size());
      end
      exp_q.delete();
      exp_cyc_q.delete();
      obs_q.delete();
      obs_cyc_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn     = 1'b0;
      preload  = 1'b1;
      LVBL     = 1'b1;
      LHBL     = 1'b1;
      cpu_cs   = 1'b0;
      cpu_we   = 1'b0;
      cpu_dsn  = 2'b11;
      cpu_addr = '0;
      cpu_dout = '0;
      vid_req  = 1'b0;
      vid_addr = AW'($urandom);
      repeat (3) @(posedge clk);
      #1;
      preload = 1'b0;
      @(negedge clk);
      n_checks++; if (cpu_din !== '0)    begin n_fail++; $display("FAIL reset_cpu_din: %h, required 0", cpu_din); end
      n_checks++; if (vid_ack !== 1'b0)  begin n_fail++; $display("FAIL reset_vid_ack: %b, required 0", vid_ack); end
      n_checks++; if (vid_data !== '0)   begin n_fail++; $display("FAIL reset_vid_data: %h, required 0", vid_data); end
      n_checks++; if (ram_we !== 2'b00)  begin n_fail++; $display("FAIL reset_ram_we: %b, required 00", ram_we); end
      n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b, required 0", cpu_busy); end
      n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: %0d, required 0 (IDLE)", state_dbg); end
      @(posedge clk); #1;
      rstn     = 1'b1;
      vid_addr = AW'($urandom);
      @(negedge clk);
      n_checks++; if (ram_addr !== vid_addr) begin n_fail++; $display("FAIL idle_ram_addr: %h, required %h", ram_addr, vid_addr); end
      n_checks++; if (ram_we !== 2'b00)      begin n_fail++; $display("FAIL idle_ram_we: %b, required 00", ram_we); end
      exp_din = '0;
   endtask

   task automatic test_read_active();
      int busy; logic [DW-1:0] rd; int wes; logic [1:0] wp; logic [DW-1:0] e;
      e = shadow[13'h0123];
      cpu_txn(1'b0, 13'h0123, 16'h0, 2'b00, 40, -1, '0, busy, rd, wes, wp);
      // the cycle cs rises counts as busy, then 39 waiting cycles, the grant
      // cycle and the access window
      n_checks++; if (busy !== 40 + WAIT_CYC + 1) begin n_fail++; $display("FAIL read_busy_len: %0d, required %0d", busy, 40 + WAIT_CYC + 1); end
      n_checks++; if (rd !== e)  begin n_fail++; $display("FAIL read_data: %h, required %h", rd, e); end
      n_checks++; if (wes !== 0) begin n_fail++; $display("FAIL read_no_write: %0d write cycles, required 0", wes); end
      exp_din = e;
   endtask

   task automatic test_write_blank();
      int busy; logic [DW-1:0] rd; int wes; logic [1:0] wp; logic [DW-1:0] e;
      e = {shadow[13'h0010][15:8], 8'hCD};
      cpu_txn(1'b1, 13'h0010, 16'hABCD, 2'b10, 0, -1, '0, busy, rd, wes, wp);
      n_checks++; if (busy !== WAIT_CYC + 2) begin n_fail++; $display("FAIL write_busy_len: %0d, required %0d", busy, WAIT_CYC + 2); end
      n_checks++; if (wes !== 1)     begin n_fail++; $display("FAIL write_we_cycles: %0d, required 1", wes); end
      n_checks++; if (wp !== 2'b01)  begin n_fail++; $display("FAIL write_we_lanes: %b, required 01", wp); end
      n_checks++; if (mem[13'h0010] !== e) begin n_fail++; $display("FAIL write_ram: %h, required %h", mem[13'h0010], e); end
      n_checks++; if (rd !== exp_din) begin n_fail++; $display("FAIL write_keeps_din: %h, required %h", rd, exp_din); end
   endtask

   task automatic test_tie();
      int busy; logic [DW-1:0] rd; int wes; logic [1:0] wp; logic [DW-1:0] d;
      d = 16'($urandom);
      cpu_txn(1'b1, 13'h0200, d, 2'b00, 0, 1, 13'h0300, busy, rd, wes, wp);
      n_checks++; if (busy !== WAIT_CYC + 3) begin n_fail++; $display("FAIL tie_busy_len: %0d, required %0d", busy, WAIT_CYC + 3); end
      n_checks++; if (mem[13'h0200] !== d) begin n_fail++; $display("FAIL tie_write: %h, required %h", mem[13'h0200], d); end
      check_video("tie");
   endtask

   task automatic test_vid_mid_access();
      int busy; logic [DW-1:0] rd; int wes; logic [1:0] wp; logic [DW-1:0] e;
      for (int k = 2; k <= 1 + WAIT_CYC; k++) begin
         e = shadow[13'h0444];
         cpu_txn(1'b0, 13'h0444, 16'h0, 2'b00, 0, k, AW'(13'h0500 + k), busy, rd, wes, wp);
         n_checks++; if (rd !== e) begin n_fail++; $display("FAIL mid_read_data: %h, required %h", rd, e); end
         exp_din = e;
         check_video("mid_access");
      end
   endtask

   task automatic test_cs_drop();
      int we0; int c; logic [DW-1:0] d;
      // drop in WAIT_BLANK: no RAM operation at all
      we0 = we_total;
      @(posedge clk); #1;
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_dsn = 2'b00; cpu_addr = 13'h0600; cpu_dout = 16'h1234;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL drop_wait_busy: %b, required 1", cpu_busy); end
      @(posedge clk); #1;
      cpu_cs = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      LHBL = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      LHBL = 1'b1;
      n_checks++; if (we_total !== we0) begin n_fail++; $display("FAIL drop_wait_no_write: %0d write cycles, required 0", we_total - we0); end

      // drop in the middle of a write: it still completes, and the arbiter
      // goes to IDLE so a fresh cs rise is busy again
      d   = 16'($urandom);
      we0 = we_total;
      @(posedge clk); #1;
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_dsn = 2'b00; cpu_addr = 13'h0700; cpu_dout = d;
      LHBL = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cpu_cs = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cpu_cs = 1'b1; cpu_we = 1'b0;
      shadow[13'h0700] = d;
      @(negedge clk);
      n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL drop_access_state: %0d, required 0 (IDLE)", state_dbg); end
      n_checks++; if (cpu_busy !== 1'b1)  begin n_fail++; $display("FAIL drop_access_rebusy: %b, required 1", cpu_busy); end
      c = 0;
      while (cpu_busy === 1'b1 && c < 50) begin
         @(negedge clk);
         c++;
      end
      n_checks++; if (cpu_din !== d) begin n_fail++; $display("FAIL drop_access_readback: %h, required %h", cpu_din, d); end
      exp_din = d;
      @(posedge clk); #1;
      cpu_cs = 1'b0; LHBL = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (we_total - we0 !== 1) begin n_fail++; $display("FAIL drop_access_we_cycles: %0d, required 1", we_total - we0); end
   endtask

   task automatic test_video_stream();
      LHBL = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         // a run of back-to-back requests, then random gaps
         vid_req = (i < 5) ? 1'b1 : 1'($urandom_range(0, 1));
         if (vid_req) begin
            vid_addr = AW'($urandom);
            exp_q.push_back(shadow[vid_addr]);
            exp_cyc_q.push_back(cyc + 1);
         end
      end
      @(posedge clk); #1;
      vid_req = 1'b0;
      LHBL = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_video("stream");
   endtask

   task automatic test_random();
      int busy; logic [DW-1:0] rd; int wes; logic [1:0] wp;
      logic we; logic [AW-1:0] a, va; logic [DW-1:0] d, e; logic [1:0] dsn;
      int bd, vc, g0, exp_busy, exp_we;
      for (int t = 0; t < 16; t++) begin
         we  = 1'($urandom_range(0, 1));
         a   = AW'($urandom);
         va  = a ^ AW'($urandom_range(1, DEPTH - 1));
         d   = 16'($urandom);
         dsn = 2'($urandom_range(0, 3));
         bd  = $urandom_range(0, 10);
         g0  = (bd < 1) ? 1 : bd;
         vc  = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, g0 + WAIT_CYC);
         e   = shadow[a];
         exp_busy = model_grant(bd, vc) + WAIT_CYC + 1;
         exp_we   = (we && dsn != 2'b11) ? 1 : 0;
         cpu_txn(we, a, d, dsn, bd, vc, va, busy, rd, wes, wp);
         n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rand%0d_busy_len: %0d, required %0d", t, busy, exp_busy); end
         n_checks++; if (wes !== exp_we) begin n_fail++; $display("FAIL rand%0d_we_cycles: %0d, required %0d", t, wes, exp_we); end
         if (we) begin
            n_checks++; if (mem[a] !== shadow[a]) begin n_fail++; $display("FAIL rand%0d_ram: %h, required %h", t, mem[a], shadow[a]); end
            n_checks++; if (rd !== exp_din) begin n_fail++; $display("FAIL rand%0d_keeps_din: %h, required %h", t, rd, exp_din); end
         end else begin
            n_checks++; if (rd !== e) begin n_fail++; $display("FAIL rand%0d_read: %h, required %h", t, rd, e); end
            exp_din = e;
         end
         check_video("random");
      end
   endtask

   task automatic test_reset_mid_access();
      int we0; logic [DW-1:0] e;
      we0 = we_total;
      e   = shadow[13'h0800];
      @(posedge clk); #1;
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_dsn = 2'b00; cpu_addr = 13'h0800; cpu_dout = ~e;
      LHBL = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b0;   // first access cycle, write would be issued here
      @(negedge clk);
      n_checks++; if (ram_we !== 2'b00) begin n_fail++; $display("FAIL rst_cycle_ram_we: %b, required 00", ram_we); end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_state: %0d, required 0 (IDLE)", state_dbg); end
      n_checks++; if (cpu_din !== '0)     begin n_fail++; $display("FAIL rst_cpu_din: %h, required 0", cpu_din); end
      n_checks++; if (vid_ack !== 1'b0)   begin n_fail++; $display("FAIL rst_vid_ack: %b, required 0", vid_ack); end
      n_checks++; if (vid_data !== '0)    begin n_fail++; $display("FAIL rst_vid_data: %h, required 0", vid_data); end
      n_checks++; if (ram_we !== 2'b00)   begin n_fail++; $display("FAIL rst_ram_we: %b, required 00", ram_we); end
      n_checks++; if (cpu_busy !== 1'b1)  begin n_fail++; $display("FAIL rst_busy_follows_cs: %b, required 1", cpu_busy); end
      @(posedge clk); #1;
      rstn = 1'b1; cpu_cs = 1'b0; LHBL = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (we_total !== we0) begin n_fail++; $display("FAIL rst_no_write: %0d write cycles, required 0", we_total - we0); end
      n_checks++; if (mem[13'h0800] !== e) begin n_fail++; $display("FAIL rst_ram_kept: %h, required %h", mem[13'h0800], e); end
      exp_din = '0;
   endtask

   initial begin
      ram_seed = 16'($urandom);
      for (int i = 0; i < DEPTH; i++) shadow[i] = ram_init(i);
      test_reset();
      test_read_active();
      test_write_blank();
      test_tie();
      test_vid_mid_access();
      test_cs_drop();
      test_video_stream();
      test_random();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
